count_seq_checker: RTL
======================

COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter WIDTH, default 3: width of the observed counter value.
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cnt_value  input  WIDTH  output of the observed up-counter.
REQ-006 cnt_en  input  1  enable driven into the observed counter.
REQ-007 cnt_clr  input  1  synchronous clear driven into the observed counter.
REQ-008 locked  output  1  high while the checker is tracking the sequence.
REQ-009 mismatch  output  1  one-cycle pulse on a detected sequence error.
REQ-010 wrap  output  1  one-cycle pulse on an observed increment from all-ones to zero.
REQ-011 expected  output  WIDTH  predicted value for the next sample.
REQ-012 err_count  output  ERR_W  saturating count of mismatches.

Function
REQ-013 All inputs are sampled on every rising clk edge; there is no handshake, and every edge is a sample.
REQ-014 The prediction for the next sample is:
  - 0 if cnt_clr=1;
  - otherwise cnt_value+1 modulo 2^WIDTH if cnt_en=1;
  - otherwise cnt_value.
REQ-015 Prediction priority is cnt_clr over cnt_en.
REQ-016 The state machine has four states: IDLE, ACQUIRE, LOCKED and FAULT.
REQ-017 IDLE: the first sample after reset loads expected from REQ-014 and moves to ACQUIRE; no comparison is made.
REQ-018 ACQUIRE, sample equal to expected: reload expected and move to LOCKED.
REQ-019 ACQUIRE, sample not equal to expected: reload expected and stay in ACQUIRE; no mismatch pulse and no err_count change.
REQ-020 LOCKED, sample equal to expected: reload expected and stay in LOCKED.
REQ-021 LOCKED, sample not equal to expected: on the following cycle, pulse mismatch, increment err_count and drop locked.
  - The next state is ACQUIRE, or FAULT per REQ-030.
  - expected is reloaded from the offending sample.
REQ-022 locked=1 exactly while in LOCKED; it is a registered output with one cycle of latency from the deciding sample.
REQ-023 wrap is pulsed the cycle after a LOCKED matching sample with:
  - the previous sample all-ones;
  - the previous cnt_en=1 and cnt_clr=0;
  - the current sample 0.
REQ-024 A clear-to-zero, or a matching zero reached while held, does not assert wrap.
REQ-025 err_count saturates at 2^ERR_W-1 and never rolls over.
REQ-026 mismatch and wrap never assert in the same cycle.
REQ-027 cnt_en=0 with a constant value is a valid sequence (hold) and shall not raise mismatch.

Reset
REQ-028 While reset=0, regardless of clk, outputs and state shall be:
  - state=IDLE;
  - locked=0, mismatch=0, wrap=0, expected=0, err_count=0.
REQ-029 Deasserting reset mid-sequence restarts from IDLE.
  - err_count is cleared.
  - The first post-reset sample is never flagged.

Configuration
REQ-030 Macro COUNT_SEQ_CHECKER_STICKY_FAULT_EN controls mismatch handling in LOCKED.
  - Defined: a mismatch in LOCKED enters FAULT.
  - FAULT holds locked=0, freezes expected and err_count, and ignores all samples until reset.
  - Undefined: FAULT is unreachable and a mismatch re-enters ACQUIRE per REQ-021.

Verification (WIDTH=3, ERR_W=8)
REQ-031 Stimulus: reset released; cnt_en=1; counter runs 0..7,0,1. Required response:
  - locked=1 from the third sample onward;
  - one wrap pulse after the 7->0 sample;
  - mismatch never asserts.
REQ-032 Stimulus: while locked at value 4 with cnt_en=1, cnt_value is forced to 6 for one sample. Required response:
  - mismatch pulses once;
  - err_count=1;
  - locked=0;
  - locked returns to 1 two samples later (non-sticky build).
REQ-033 Stimulus: cnt_clr=1 while the counter is at 5, then the counter reads 0. Required response:
  - no mismatch;
  - no wrap;
  - locked stays 1.
REQ-034 Stimulus: cnt_en=0 for 4 cycles at value 3. Required response:
  - expected=3 throughout;
  - no mismatch.
REQ-035 Stimulus: 300 forced mismatches. Required response: err_count=255 and it stays at 255.
REQ-036 Stimulus: sticky build with one mismatch, then a correct sequence. Required response:
  - locked stays 0 and err_count stays 1 until reset=0;
  - after reset, all outputs are 0.

Source files
------------

// File: rtl/count_seq_checker.sv
// count_seq_checker: watches a free-running up-counter (value, enable, clear)
// and checks that each sampled value matches the prediction made from the
// previous sample. It reports lock status, a mismatch pulse, a wrap pulse
// and a saturating error count.
//
// Interface timing: there is no valid/ready handshake. Every rising clk edge
// samples cnt_value/cnt_en/cnt_clr, and all outputs are registered. Each
// output reflects the sample taken at the most recent edge.
//
// Build option: define COUNT_SEQ_CHECKER_STICKY_FAULT_EN to make a mismatch
// in LOCKED enter FAULT. FAULT ignores all samples until reset. Without the
// macro, a mismatch returns to ACQUIRE.
module count_seq_checker #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_value,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             locked_q, locked_d;
  logic             mismatch_q, mismatch_d;
  logic             wrap_q, wrap_d;
  logic             prev_max_inc_q;

  logic [WIDTH-1:0] pred;
  logic             match;
  logic             max_inc;
  logic [ERR_W-1:0] err_sat_inc;

  // The counter's next value: a clear wins over an enable, otherwise it holds.
  assign pred = cnt_clr ? '0 : (cnt_en ? cnt_value + WIDTH'(1) : cnt_value);

  assign match = (cnt_value == expected_q);

  // This sample is all-ones and is being incremented, so the next sample wraps.
  assign max_inc = (cnt_value == '1) && cnt_en && !cnt_clr;

  assign err_sat_inc = (err_q == '1) ? err_q : err_q + ERR_W'(1);

  // Next-state and next-output decode for the tracking FSM.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    err_d      = err_q;
    mismatch_d = 1'b0;
    wrap_d     = 1'b0;
    locked_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // The first sample after reset only seeds the prediction.
        expected_d = pred;
        state_d    = ACQUIRE;
      end
      ACQUIRE: begin
        expected_d = pred;
        if (match) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // On a mismatch, re-seed from the offending sample so we can relock.
        expected_d = pred;
        if (match) begin
          wrap_d = prev_max_inc_q && (cnt_value == '0);
        end else begin
          mismatch_d = 1'b1;
          err_d      = err_sat_inc;
`ifdef COUNT_SEQ_CHECKER_STICKY_FAULT_EN
          state_d    = FAULT;
`else
          state_d    = ACQUIRE;
`endif
        end
      end
      FAULT: begin
        // Frozen until reset: prediction and error count are held.
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      expected_q     <= '0;
      err_q          <= '0;
      locked_q       <= 1'b0;
      mismatch_q     <= 1'b0;
      wrap_q         <= 1'b0;
      prev_max_inc_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      err_q          <= err_d;
      locked_q       <= locked_d;
      mismatch_q     <= mismatch_d;
      wrap_q         <= wrap_d;
      prev_max_inc_q <= max_inc;
    end
  end

  assign locked    = locked_q;
  assign mismatch  = mismatch_q;
  assign wrap      = wrap_q;
  assign expected  = expected_q;
  assign err_count = err_q;
  assign state     = state_q;

endmodule
